// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Contents: register address/data widths, register count, the zero-register
// address, the enable/reset encodings, the LU result entry type and the
// occupancy counter width helper.
package regfile_wport_arbiter_pkg;

  localparam int unsigned AW     = 5;
  localparam int unsigned DW     = 32;
  localparam int unsigned RegNum = 1 << AW;

  localparam logic [AW-1:0] ZeroRegAddr = '0;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;
  localparam logic RstEnable    = 1'b1;
  localparam logic RstDisable   = 1'b0;

  // One queued long-latency-unit result
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } lu_entry_t;

  // Width able to hold the values 0..depth
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// Bus bundle of the write-port arbiter.
// master: pipeline/LU/decode side (drives write-back, issue, LU result and
//         decode requests; observes ready, stall, write port and forwards).
// slave:  the arbiter itself.
interface regfile_wport_arbiter_if
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic          wb_we;
  logic [AW-1:0] wb_waddr;
  logic [DW-1:0] wb_wdata;
  logic          iss_valid;
  logic [AW-1:0] iss_addr;
  logic          iss_ready;
  logic          lu_valid;
  logic [AW-1:0] lu_addr;
  logic [DW-1:0] lu_data;
  logic          lu_ready;
  logic          re1;
  logic [AW-1:0] rAddr1;
  logic          re2;
  logic [AW-1:0] rAddr2;
  logic          dec_we;
  logic [AW-1:0] dec_waddr;
  logic          stall;
  logic          we;
  logic [AW-1:0] wAddr;
  logic [DW-1:0] wData;
  logic [CW-1:0] fifo_cnt;
  logic          fwd1_hit;
  logic [DW-1:0] fwd1_data;
  logic          fwd2_hit;
  logic [DW-1:0] fwd2_data;

  modport master (
    output wb_we, wb_waddr, wb_wdata,
    output iss_valid, iss_addr,
    output lu_valid, lu_addr, lu_data,
    output re1, rAddr1, re2, rAddr2, dec_we, dec_waddr,
    input  iss_ready, lu_ready, stall,
    input  we, wAddr, wData, fifo_cnt,
    input  fwd1_hit, fwd1_data, fwd2_hit, fwd2_data
  );

  modport slave (
    input  wb_we, wb_waddr, wb_wdata,
    input  iss_valid, iss_addr,
    input  lu_valid, lu_addr, lu_data,
    input  re1, rAddr1, re2, rAddr2, dec_we, dec_waddr,
    output iss_ready, lu_ready, stall,
    output we, wAddr, wData, fifo_cnt,
    output fwd1_hit, fwd1_data, fwd2_hit, fwd2_data
  );

endinterface

// File: rtl/regfile_wport_arbiter_fifo.sv
// wbarb_fifo: DEPTH-entry FIFO of LU results with registered count.
// Ports: clk, rst (async, active high), push/push_entry, pop, head (oldest
// entry), cnt, full, empty. With WBARB_FWD_EN defined, two address lookup
// ports report the youngest queued entry matching q1_addr/q2_addr.
module wbarb_fifo
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  lu_entry_t     push_entry,
  input  logic          pop,
  output lu_entry_t     head,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          empty
`ifdef WBARB_FWD_EN
  ,
  input  logic [AW-1:0] q1_addr,
  input  logic [AW-1:0] q2_addr,
  output logic          q1_hit,
  output logic [DW-1:0] q1_data,
  output logic          q2_hit,
  output logic [DW-1:0] q2_data
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  lu_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

`ifdef WBARB_FWD_EN
  // Slot holding the entry 'off' positions younger than the head
  function automatic logic [PW-1:0] slot_of(input logic [PW-1:0] base,
                                            input int unsigned off);
    logic [PW:0] s;
    s = {1'b0, base} + (PW+1)'(off);
    if (s >= (PW+1)'(DEPTH)) s = s - (PW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  // Walk oldest to youngest so the youngest match is left standing
  always_comb begin
    q1_hit  = 1'b0;
    q1_data = '0;
    q2_hit  = 1'b0;
    q2_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) < cnt) begin
        if (mem[slot_of(rd_ptr, i)].addr == q1_addr) begin
          q1_hit  = 1'b1;
          q1_data = mem[slot_of(rd_ptr, i)].data;
        end
        if (mem[slot_of(rd_ptr, i)].addr == q2_addr) begin
          q2_hit  = 1'b1;
          q2_data = mem[slot_of(rd_ptr, i)].data;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter: shares the register-file write port between the
// pipeline write-back (always wins) and queued long-latency-unit results,
// which drain into idle write-port cycles. A per-register busy scoreboard
// tracks LU destinations in flight and raises a decode stall on RAW/WAW.
// Ports: clk, rst (async, active high) and the regfile_wport_arbiter_if
// slave bundle (write-back, LU issue/result, decode reads, write port,
// FIFO occupancy, forwarding).
// Build option: WBARB_FWD_EN forwards queued LU data to the decode read
// ports and removes the RAW stall for a forwarded port.
module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input logic                   clk,
  input logic                   rst,
  regfile_wport_arbiter_if.slave bus
);

  localparam int unsigned CW = cnt_width(DEPTH);

  lu_entry_t           head;
  lu_entry_t           push_entry;
  logic [CW-1:0]       cnt;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                pipe_own;
  logic                iss_ready_c;
  logic                iss_fire;
  logic [RegNum-1:0]   busy;
  logic [RegNum-1:0]   busy_nxt;
  logic                raw1;
  logic                raw2;
  logic                waw;
  logic                fwd1;
  logic                fwd2;
  logic                hit1;
  logic                hit2;
  logic [DW-1:0]       hit1_data;
  logic [DW-1:0]       hit2_data;

  assign pipe_own   = (bus.wb_we == WriteEnable) && (bus.wb_waddr != ZeroRegAddr);
  assign pop        = !rst && !pipe_own && !empty;
  assign push       = !rst && bus.lu_valid && !full;
  assign push_entry = '{addr: bus.lu_addr, data: bus.lu_data};

  wbarb_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .cnt        (cnt),
    .full       (full),
    .empty      (empty)
`ifdef WBARB_FWD_EN
    ,
    .q1_addr    (bus.rAddr1),
    .q2_addr    (bus.rAddr2),
    .q1_hit     (hit1),
    .q1_data    (hit1_data),
    .q2_hit     (hit2),
    .q2_data    (hit2_data)
`endif
  );

`ifndef WBARB_FWD_EN
  assign hit1      = 1'b0;
  assign hit2      = 1'b0;
  assign hit1_data = '0;
  assign hit2_data = '0;
`endif

  assign bus.fifo_cnt = cnt;
  assign bus.lu_ready = !rst && !full;

  // Write-port mux; a zero-destination head still pops but writes nothing
  always_comb begin
    bus.we    = WriteDisable;
    bus.wAddr = '0;
    bus.wData = '0;
    if (!rst) begin
      if (pipe_own) begin
        bus.we    = WriteEnable;
        bus.wAddr = bus.wb_waddr;
        bus.wData = bus.wb_wdata;
      end else if (!empty && (head.addr != ZeroRegAddr)) begin
        bus.we    = WriteEnable;
        bus.wAddr = head.addr;
        bus.wData = head.data;
      end
    end
  end

  // busy[0] is never set, so address 0 always reads as ready
  assign iss_ready_c   = !rst && !busy[bus.iss_addr];
  assign bus.iss_ready = iss_ready_c;
  assign iss_fire      = bus.iss_valid && iss_ready_c && (bus.iss_addr != ZeroRegAddr);

  // Scoreboard update; the set is applied last so it wins over a drain
  always_comb begin
    busy_nxt = busy;
    if (pop && (head.addr != ZeroRegAddr)) busy_nxt[head.addr] = 1'b0;
    if (iss_fire) busy_nxt[bus.iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) busy <= '0;
    else                  busy <= busy_nxt;
  end

  // Hazard detection against in-flight LU destinations
  always_comb begin
    raw1 = (bus.re1 == ReadEnable) && (bus.rAddr1 != ZeroRegAddr) && busy[bus.rAddr1];
    raw2 = (bus.re2 == ReadEnable) && (bus.rAddr2 != ZeroRegAddr) && busy[bus.rAddr2];
    waw  = (bus.dec_we == WriteEnable) && (bus.dec_waddr != ZeroRegAddr) && busy[bus.dec_waddr];
    fwd1 = raw1 && hit1;
    fwd2 = raw2 && hit2;
  end

  assign bus.stall     = !rst && ((raw1 && !fwd1) || (raw2 && !fwd2) || waw);
  assign bus.fwd1_hit  = !rst && fwd1;
  assign bus.fwd2_hit  = !rst && fwd2;
  assign bus.fwd1_data = (!rst && fwd1) ? hit1_data : '0;
  assign bus.fwd2_data = (!rst && fwd2) ? hit2_data : '0;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Self-checking bench for regfile_wport_arbiter: directed test-plan
// sequences followed by randomized traffic, all scored against a queue-based
// reference model of the arbiter rules.
module tb_regfile_wport_arbiter;
  import regfile_wport_arbiter_pkg::*;

  localparam int unsigned DEPTH = 2;
`ifdef WBARB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wport_arbiter_if #(.DEPTH(DEPTH)) bus ();

  regfile_wport_arbiter #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: queued LU results, busy registers, pending LU dests
  lu_entry_t     mq[$];
  bit            mbusy[RegNum];
  logic [AW-1:0] pend[$];
  bit            m_pushed;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    bus.wb_we = 0; bus.wb_waddr = 0; bus.wb_wdata = 0;
    bus.iss_valid = 0; bus.iss_addr = 0;
    bus.lu_valid = 0; bus.lu_addr = 0; bus.lu_data = 0;
    bus.re1 = 0; bus.rAddr1 = 0; bus.re2 = 0; bus.rAddr2 = 0;
    bus.dec_we = 0; bus.dec_waddr = 0;
  endtask

  task automatic model_clear();
    mq.delete();
    pend.delete();
    for (int i = 0; i < int'(RegNum); i++) mbusy[i] = 1'b0;
  endtask

  task automatic find_fwd(input logic [AW-1:0] a, output bit hit, output logic [DW-1:0] d);
    hit = 0;
    d   = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!hit && mq[i].addr == a) begin
        hit = 1;
        d   = mq[i].data;
      end
    end
  endtask

  task automatic check_outputs();
    bit            pipe, raw1, raw2, waw, h1, h2, f1, f2, e_we, e_stall;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data, d1, d2;
    pipe   = bus.wb_we && bus.wb_waddr != 0;
    e_we   = 0;
    e_addr = 0;
    e_data = 0;
    if (pipe) begin
      e_we = 1; e_addr = bus.wb_waddr; e_data = bus.wb_wdata;
    end else if (mq.size() > 0 && mq[0].addr != 0) begin
      e_we = 1; e_addr = mq[0].addr; e_data = mq[0].data;
    end
    raw1 = bus.re1 && bus.rAddr1 != 0 && mbusy[bus.rAddr1];
    raw2 = bus.re2 && bus.rAddr2 != 0 && mbusy[bus.rAddr2];
    waw  = bus.dec_we && bus.dec_waddr != 0 && mbusy[bus.dec_waddr];
    find_fwd(bus.rAddr1, h1, d1);
    find_fwd(bus.rAddr2, h2, d2);
    f1 = FWD && raw1 && h1;
    f2 = FWD && raw2 && h2;
    e_stall = (raw1 && !f1) || (raw2 && !f2) || waw;
    chk("we",        64'(bus.we),        64'(e_we));
    chk("wAddr",     64'(bus.wAddr),     64'(e_addr));
    chk("wData",     64'(bus.wData),     64'(e_data));
    chk("fifo_cnt",  64'(bus.fifo_cnt),  64'(mq.size()));
    chk("lu_ready",  64'(bus.lu_ready),  64'(mq.size() != DEPTH));
    chk("iss_ready", 64'(bus.iss_ready), 64'(bus.iss_addr == 0 || !mbusy[bus.iss_addr]));
    chk("stall",     64'(bus.stall),     64'(e_stall));
    chk("fwd1_hit",  64'(bus.fwd1_hit),  64'(f1));
    chk("fwd1_data", 64'(bus.fwd1_data), f1 ? 64'(d1) : 64'(0));
    chk("fwd2_hit",  64'(bus.fwd2_hit),  64'(f2));
    chk("fwd2_data", 64'(bus.fwd2_data), f2 ? 64'(d2) : 64'(0));
  endtask

  // Advance the model by one clock edge using the rules as written
  task automatic update_model();
    bit        pipe, iss_rdy, lu_rdy;
    lu_entry_t h;
    pipe    = bus.wb_we && bus.wb_waddr != 0;
    iss_rdy = bus.iss_addr == 0 || !mbusy[bus.iss_addr];
    lu_rdy  = mq.size() != DEPTH;
    m_pushed = 0;
    if (!pipe && mq.size() > 0) begin
      h = mq.pop_front();
      if (h.addr != 0) mbusy[h.addr] = 1'b0;
    end
    if (bus.iss_valid && iss_rdy && bus.iss_addr != 0) begin
      mbusy[bus.iss_addr] = 1'b1;
      pend.push_back(bus.iss_addr);
    end
    if (bus.lu_valid && lu_rdy) begin
      mq.push_back('{addr: bus.lu_addr, data: bus.lu_data});
      m_pushed = 1;
      if (pend.size() > 0 && pend[0] == bus.lu_addr) void'(pend.pop_front());
    end
  endtask

  task automatic tick();
    #1;
    check_outputs();
    update_model();
    @(negedge clk);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, ".we"},        64'(bus.we),        64'(0));
    chk({tag, ".wAddr"},     64'(bus.wAddr),     64'(0));
    chk({tag, ".wData"},     64'(bus.wData),     64'(0));
    chk({tag, ".fifo_cnt"},  64'(bus.fifo_cnt),  64'(0));
    chk({tag, ".stall"},     64'(bus.stall),     64'(0));
    chk({tag, ".lu_ready"},  64'(bus.lu_ready),  64'(0));
    chk({tag, ".iss_ready"}, 64'(bus.iss_ready), 64'(0));
    chk({tag, ".fwd1_hit"},  64'(bus.fwd1_hit),  64'(0));
    chk({tag, ".fwd2_hit"},  64'(bus.fwd2_hit),  64'(0));
  endtask

  task automatic set_wb(input bit e, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wb_we = e; bus.wb_waddr = a; bus.wb_wdata = d;
  endtask

  task automatic set_lu(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.lu_valid = v; bus.lu_addr = a; bus.lu_data = d;
  endtask

  task automatic set_iss(input bit v, input logic [AW-1:0] a);
    bus.iss_valid = v; bus.iss_addr = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset with live inputs so the zeroing is observable
    rst = 1'b1;
    idle();
    set_wb(1, 3, 32'h1234);
    set_iss(1, 5);
    bus.re1 = 1; bus.rAddr1 = 5;
    @(negedge clk);
    #1 reset_check("por");
    model_clear();
    idle();
    rst = 1'b0;
    @(negedge clk);

    // Issue r5, LU result behind two write-back cycles, RAW read on r5
    set_iss(1, 5); set_wb(1, 3, 32'h1111);
    tick();
    set_iss(0, 0); set_lu(1, 5, 32'hDEADBEEF); set_wb(1, 3, 32'h2222);
    bus.re1 = 1; bus.rAddr1 = 5;
    tick();
    set_lu(0, 0, 0); set_wb(0, 0, 0);
    tick();
    tick();
    idle();

    // Fill the FIFO while write-back holds the port; third result waits
    set_wb(1, 2, 32'hAAAA);
    set_iss(1, 1);
    tick();
    set_iss(1, 4); set_lu(1, 1, 32'h0101);
    tick();
    set_iss(0, 0); set_lu(1, 4, 32'h0404);
    bus.re2 = 1; bus.rAddr2 = 4; bus.dec_we = 1; bus.dec_waddr = 1;
    tick();
    set_lu(1, 6, 32'h0606);
    tick();
    tick();
    set_wb(0, 0, 0);
    begin
      int n = 0;
      while (!m_pushed && n < 10) begin
        tick();
        n++;
      end
      chk("held_result_accepted", 64'(m_pushed), 64'(1));
    end
    set_lu(0, 0, 0);
    repeat (4) tick();
    idle();

    // Re-issue to a busy register, then issue/read of r0
    set_iss(1, 7);
    tick();
    set_iss(1, 7);
    tick();
    set_iss(1, 0); bus.re1 = 1; bus.rAddr1 = 0; bus.re2 = 1; bus.rAddr2 = 7;
    tick();
    idle();
    set_lu(1, 7, 32'h0707);
    tick();
    set_lu(1, 0, 32'hBAD0);
    tick();
    set_lu(0, 0, 0);
    repeat (3) tick();

    // Unissued r9 result drains on the same edge r9 is issued
    set_wb(1, 8, 32'h8888); set_lu(1, 9, 32'h0909);
    tick();
    set_wb(0, 0, 0); set_lu(0, 0, 0); set_iss(1, 9);
    tick();
    idle();
    bus.re1 = 1; bus.rAddr1 = 9;
    tick();
    set_lu(1, 9, 32'h9999);
    tick();
    set_lu(0, 0, 0);
    repeat (3) tick();
    idle();

    // Reset mid-operation: two queued entries and busy r5
    set_wb(1, 3, 32'h3333); set_iss(1, 5);
    tick();
    set_iss(0, 0); set_lu(1, 5, 32'h5555);
    tick();
    set_lu(1, 6, 32'h6666);
    tick();
    set_lu(0, 0, 0);
    chk("pre_reset_cnt", 64'(bus.fifo_cnt), 64'(2));
    rst = 1'b1;
    #1 reset_check("midrst");
    model_clear();
    @(negedge clk);
    idle();
    rst = 1'b0;
    set_iss(0, 5); bus.re1 = 1; bus.rAddr1 = 5;
    tick();
    idle();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      idle();
      if ($urandom_range(0, 99) < 45)
        set_wb(1, AW'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 99) < 35)
        set_iss(1, AW'($urandom_range(0, 15)));
      else
        bus.iss_addr = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 40) begin
        if (pend.size() > 0 && $urandom_range(0, 99) < 75)
          set_lu(1, pend[0], $urandom);
        else
          set_lu(1, AW'($urandom_range(0, 15)), $urandom);
      end
      bus.re1 = 1'($urandom_range(0, 1)); bus.rAddr1 = AW'($urandom_range(0, 15));
      bus.re2 = 1'($urandom_range(0, 1)); bus.rAddr2 = AW'($urandom_range(0, 15));
      bus.dec_we = 1'($urandom_range(0, 1)); bus.dec_waddr = AW'($urandom_range(0, 15));
      tick();
    end

    idle();
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
